// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, operand-select encodings and
// forwarding helpers used by the ID/EX stage.
package cpu_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [4:0] ALU_SLL  = 5'b00000;
    localparam logic [4:0] ALU_SRL  = 5'b00010;
    localparam logic [4:0] ALU_SRA  = 5'b00011;
    localparam logic [4:0] ALU_SLLV = 5'b00100;
    localparam logic [4:0] ALU_ADD  = 5'b10000;
    localparam logic [4:0] ALU_ADDU = 5'b10001;
    localparam logic [4:0] ALU_SUB  = 5'b10010;
    localparam logic [4:0] ALU_AND  = 5'b10100;
    localparam logic [4:0] ALU_OR   = 5'b10101;
    localparam logic [4:0] ALU_LUI  = 5'b11000;

    typedef enum logic [1:0] {
        A_RS   = 2'b00,
        A_SA   = 2'b01,
        A_PC   = 2'b10,
        A_ZERO = 2'b11
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RT    = 2'b00,
        B_SEXT  = 2'b01,
        B_ZEXT  = 2'b10,
        B_EIGHT = 2'b11
    } b_sel_e;

    // A writer matches a source only for a nonzero index.
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                     input logic [4:0] idx);
        return we && (rd == idx) && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: MEM result beats WB result beats the captured value.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [4:0]   idx,
    input  logic [W-1:0] cap_val,
    input  logic         mem_we,
    input  logic [4:0]   mem_rd,
    input  logic [W-1:0] mem_data,
    input  logic         wb_we,
    input  logic [4:0]   wb_rd,
    input  logic [W-1:0] wb_data,
    output logic [W-1:0] val
);

    always_comb begin
        val = cap_val;
        if (fwd_hit(mem_we, mem_rd, idx))
            val = mem_data;
        else if (fwd_hit(wb_we, wb_rd, idx))
            val = wb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, A/B operand select,
// load-use hazard detection, flush and downstream stall.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid,
    input  logic [W-1:0] id_pc,
    input  logic [W-1:0] id_rs_val,
    input  logic [W-1:0] id_rt_val,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic         id_use_rs,
    input  logic         id_use_rt,
    input  logic [4:0]   id_sa,
    input  logic [15:0]  id_imm,
    input  logic [4:0]   id_alu_op,
    input  logic [1:0]   id_a_sel,
    input  logic [1:0]   id_b_sel,
    input  logic         id_reg_we,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic [4:0]   mem_rd,
    input  logic         mem_we,
    input  logic [W-1:0] mem_data,
    input  logic [4:0]   wb_rd,
    input  logic         wb_we,
    input  logic [W-1:0] wb_data,
    input  logic         flush,
    input  logic         stall_in,
    output logic         stall_out,
    output logic         ex_valid,
    output logic [W-1:0] ex_pc,
    output logic [4:0]   ex_alu_op,
    output logic [W-1:0] ex_alu_a,
    output logic [W-1:0] ex_alu_b,
    output logic [W-1:0] ex_store_data,
    output logic [4:0]   ex_rd,
    output logic         ex_reg_we,
    output logic         ex_mem_read,
    output logic         ex_mem_write
);

    typedef struct packed {
        logic         valid;
        logic [W-1:0] pc;
        logic [4:0]   alu_op;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [W-1:0] rs_val;
        logic [W-1:0] rt_val;
        logic [4:0]   sa;
        logic [15:0]  imm;
        a_sel_e       a_sel;
        b_sel_e       b_sel;
        logic [4:0]   rd;
        logic         reg_we;
        logic         mem_read;
        logic         mem_write;
    } ex_reg_t;

    ex_reg_t      r;
    ex_reg_t      id_next;
    logic [W-1:0] rs_fwd;
    logic [W-1:0] rt_fwd;
    logic         rs_dep;
    logic         rt_dep;

    // WB writes the register file this same cycle, so the RF read is stale.
    always_comb begin
        id_next           = '0;
        id_next.valid     = id_valid;
        id_next.pc        = id_pc;
        id_next.alu_op    = id_alu_op;
        id_next.rs        = id_rs;
        id_next.rt        = id_rt;
        id_next.rs_val    = fwd_hit(wb_we, wb_rd, id_rs) ? wb_data : id_rs_val;
        id_next.rt_val    = fwd_hit(wb_we, wb_rd, id_rt) ? wb_data : id_rt_val;
        id_next.sa        = id_sa;
        id_next.imm       = id_imm;
        id_next.a_sel     = a_sel_e'(id_a_sel);
        id_next.b_sel     = b_sel_e'(id_b_sel);
        id_next.rd        = id_rd;
        id_next.reg_we    = id_reg_we;
        id_next.mem_read  = id_mem_read;
        id_next.mem_write = id_mem_write;
    end

    assign rs_dep    = id_use_rs && (id_rs == r.rd);
    assign rt_dep    = id_use_rt && (id_rt == r.rd);
    assign stall_out = !flush && id_valid && r.valid && r.mem_read
                       && (r.rd != REG_ZERO) && (rs_dep || rt_dep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r <= '0;
        else if (flush)
            r <= '0;
        else if (stall_in)
            r <= r;
        else if (stall_out)
            r <= '0;
        else
            r <= id_next;
    end

    fwd_mux #(.W(W)) u_fwd_rs (
        .idx      (r.rs),
        .cap_val  (r.rs_val),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .val      (rs_fwd)
    );

    fwd_mux #(.W(W)) u_fwd_rt (
        .idx      (r.rt),
        .cap_val  (r.rt_val),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .val      (rt_fwd)
    );

    always_comb begin
        ex_alu_a = '0;
        unique case (r.a_sel)
            A_RS:    ex_alu_a = rs_fwd;
            A_SA:    ex_alu_a = {{(W-5){1'b0}}, r.sa};
            A_PC:    ex_alu_a = r.pc;
            A_ZERO:  ex_alu_a = '0;
            default: ex_alu_a = '0;
        endcase
    end

    always_comb begin
        ex_alu_b = '0;
        unique case (r.b_sel)
            B_RT:    ex_alu_b = rt_fwd;
            B_SEXT:  ex_alu_b = {{(W-16){r.imm[15]}}, r.imm};
            B_ZEXT:  ex_alu_b = {{(W-16){1'b0}}, r.imm};
            B_EIGHT: ex_alu_b = W'(8);
            default: ex_alu_b = '0;
        endcase
    end

    assign ex_valid      = r.valid;
    assign ex_pc         = r.pc;
    assign ex_alu_op     = r.alu_op;
    assign ex_store_data = rt_fwd;
    assign ex_rd         = r.rd;
    assign ex_reg_we     = r.reg_we;
    assign ex_mem_read   = r.mem_read;
    assign ex_mem_write  = r.mem_write;

endmodule
